// File: rtl/if_prefetch_queue.sv
// -----------------------------------------------------------------------------
// if_prefetch_queue
//   Instruction prefetch queue that sits directly upstream of the IF stage.
//   It issues sequential word fetches to a variable-latency instruction memory
//   (req/ack), buffers up to DEPTH {pc,inst} pairs and presents the head entry
//   to the CPU. A redirect from ID flushes the queue and restarts fetching at
//   the new address; a fetch that is already outstanding is drained and its
//   data thrown away.
//
//   Optional build macro: IFQ_BYPASS_EN
//     defined   - when the queue is empty and a fetch is acked, the returning
//                 word is forwarded combinationally to inst_out/pc_out.
//     undefined - outputs come only from the registered queue head.
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-low reset
//   redirect            ID resolved a taken branch/jump this cycle
//   redirect_pc[31:0]   new fetch address, bits [1:0] ignored
//   cpu_stall           1 = CPU does not consume the head this cycle
//   inst_out[31:0]      head instruction (32'hffffffff when nothing valid)
//   pc_out[31:0]        address of inst_out (fetch pc when queue empty)
//   inst_valid          inst_out holds a real instruction
//   mem_req             fetch request, held until mem_ack
//   mem_addr[31:0]      fetch address, word aligned, stable while mem_req
//   mem_ack             memory returns mem_rdata for the held request
//   mem_rdata[31:0]     fetched instruction
//   occupancy           number of valid entries in the queue
//   o_dbg_state[1:0]    fetch FSM state (0 IDLE, 1 WAIT, 2 DROP)
//
// Handshake: mem_req rises with mem_addr valid and both stay constant until a
//   cycle in which mem_ack=1; that cycle completes the transfer (ack in the
//   first cycle of the request is allowed). The CPU side consumes the head on
//   every rising edge where inst_valid=1 and cpu_stall=0.
// -----------------------------------------------------------------------------
module if_prefetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h00400000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     redirect,
  input  logic [31:0]              redirect_pc,
  input  logic                     cpu_stall,
  output logic [31:0]              inst_out,
  output logic [31:0]              pc_out,
  output logic                     inst_valid,
  output logic                     mem_req,
  output logic [31:0]              mem_addr,
  input  logic                     mem_ack,
  input  logic [31:0]              mem_rdata,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic [1:0]               o_dbg_state
);

  localparam int AW = $clog2(DEPTH);
  localparam int OW = AW + 1;
  localparam logic [OW-1:0] DEPTH_C = OW'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;

  logic [31:0]    r_pc_q   [DEPTH];
  logic [31:0]    r_inst_q [DEPTH];
  logic [AW-1:0]  r_head;
  logic [AW-1:0]  r_tail;
  logic [OW-1:0]  r_occ;
  logic [31:0]    r_fpc;     // next sequential fetch address
  logic [31:0]    r_addr;    // address of the request on the bus

  logic           w_empty;
  logic           w_ack_wait;
  logic           w_bypass;
  logic           w_pop;
  logic           w_push;
  logic           w_issue;
  logic [OW-1:0]  w_occ_nxt;
  logic [31:0]    w_fpc_nxt;

  assign w_empty    = (r_occ == '0);
  assign w_ack_wait = (r_state == S_WAIT) && mem_ack;

`ifdef IFQ_BYPASS_EN
  // Forward the returning word straight to the CPU when nothing is queued.
  assign w_bypass = w_empty && w_ack_wait && !redirect;
`else
  assign w_bypass = 1'b0;
`endif

  // A bypassed word that the CPU takes this cycle never enters the queue;
  // if the CPU stalls it is stored like any other fetch.
  assign w_pop  = !w_empty && !cpu_stall && !redirect;
  assign w_push = w_ack_wait && !redirect && !(w_bypass && !cpu_stall);

  always_comb begin
    w_occ_nxt = r_occ;
    if (redirect) begin
      w_occ_nxt = '0;
    end else if (w_push && !w_pop) begin
      w_occ_nxt = r_occ + OW'(1);
    end else if (!w_push && w_pop) begin
      w_occ_nxt = r_occ - OW'(1);
    end
  end

  always_comb begin
    w_fpc_nxt = r_fpc;
    if (redirect) begin
      w_fpc_nxt = {redirect_pc[31:2], 2'b00};
    end else if (w_ack_wait) begin
      w_fpc_nxt = r_fpc + 32'd4;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  //   A new request is only started when the queue will still have room for
  //   its data, counting the request itself, so the queue cannot overflow.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (!redirect && (r_occ < DEPTH_C)) begin
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect) begin
          w_state_nxt = mem_ack ? S_IDLE : S_DROP;
        end else if (mem_ack) begin
          w_state_nxt = (w_occ_nxt < DEPTH_C) ? S_WAIT : S_IDLE;
        end
      end
      S_DROP: begin
        // The stale request completes; a redirect here only moves r_fpc.
        if (mem_ack) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    mem_req     = (r_state != S_IDLE);
    o_dbg_state = r_state;
  end

  // A fresh bus address is loaded whenever a new request begins.
  assign w_issue = (w_state_nxt == S_WAIT) && ((r_state == S_IDLE) || w_ack_wait);

  // ---------------------------------------------------------------------------
  // Queue pointers, occupancy and fetch address
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_head <= '0;
      r_tail <= '0;
      r_occ  <= '0;
      r_fpc  <= RESET_PC;
      r_addr <= RESET_PC;
    end else begin
      r_occ <= w_occ_nxt;
      r_fpc <= w_fpc_nxt;
      if (w_issue) begin
        r_addr <= w_fpc_nxt;
      end
      if (redirect) begin
        r_head <= '0;
        r_tail <= '0;
      end else begin
        if (w_push) begin
          r_tail <= r_tail + AW'(1);
        end
        if (w_pop) begin
          r_head <= r_head + AW'(1);
        end
      end
    end
  end

  // Storage needs no reset: entries are only read while counted in r_occ.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pc_q[r_tail]   <= r_addr;
      r_inst_q[r_tail] <= mem_rdata;
    end
  end

  // ---------------------------------------------------------------------------
  // CPU-facing outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    inst_valid = 1'b0;
    inst_out   = 32'hffffffff;
    pc_out     = r_fpc;
    if (w_bypass) begin
      inst_valid = 1'b1;
      inst_out   = mem_rdata;
      pc_out     = r_addr;
    end else if (!w_empty) begin
      inst_valid = 1'b1;
      inst_out   = r_inst_q[r_head];
      pc_out     = r_pc_q[r_head];
    end
  end

  assign mem_addr  = r_addr;
  assign occupancy = r_occ;

endmodule

// File: tb/tb_if_prefetch_queue.sv
// -----------------------------------------------------------------------------
// tb_if_prefetch_queue
//   Directed bench for if_prefetch_queue (DEPTH=4, RESET_PC=00400000).
//   Instruction memory image: word at address a is {8'h13, a[23:0]}.
//   Built with or without IFQ_BYPASS_EN; expectations follow the build.
// -----------------------------------------------------------------------------
module tb_if_prefetch_queue;

`ifdef IFQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // DUT signals
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        cpu_stall;
  logic [31:0] inst_out;
  logic [31:0] pc_out;
  logic        inst_valid;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [2:0]  occupancy;
  logic [1:0]  dbg_state;

  // memory responder: zero-wait auto mode or hand-driven ack
  logic        auto_mem;
  logic        man_ack;
  logic [31:0] man_rdata;

  function automatic logic [31:0] imem(input logic [31:0] a);
    return {8'h13, a[23:0]};
  endfunction

  assign mem_ack   = auto_mem ? mem_req : man_ack;
  assign mem_rdata = auto_mem ? imem(mem_addr) : man_rdata;

  if_prefetch_queue #(.DEPTH(4), .RESET_PC(32'h00400000)) dut (
    .clk         (clk),
    .rst         (rst),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .cpu_stall   (cpu_stall),
    .inst_out    (inst_out),
    .pc_out      (pc_out),
    .inst_valid  (inst_valid),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .occupancy   (occupancy),
    .o_dbg_state (dbg_state)
  );

  // scoreboard
  int unsigned  n_checks = 0;
  int unsigned  n_pass   = 0;
  logic [31:0]  exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst         = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    cpu_stall   = 1'b0;
    auto_mem    = 1'b1;
    man_ack     = 1'b0;
    man_rdata   = 32'h0;

    // ---- reset state ----
    step(); step();
    check("rst_req",   32'(mem_req),    32'h0);
    check("rst_valid", 32'(inst_valid), 32'h0);
    check("rst_inst",  inst_out,        32'hffffffff);
    check("rst_pc",    pc_out,          32'h00400000);
    check("rst_addr",  mem_addr,        32'h00400000);
    check("rst_occ",   32'(occupancy),  32'h0);

    // ---- zero-wait stream, no stall ----
    rst = 1'b1;
    step();
    check("first_req",   32'(mem_req),    32'h1);
    check("first_addr",  mem_addr,        32'h00400000);
    check("first_valid", 32'(inst_valid), 32'(BYP));
    if (!BYP) step();
    for (int k = 0; k < 4; k++) begin
      check("stream_pc",    pc_out,          32'h00400000 + 32'(4 * k));
      check("stream_inst",  inst_out,        imem(32'h00400000 + 32'(4 * k)));
      check("stream_valid", 32'(inst_valid), 32'h1);
      check("stream_occ",   32'(occupancy),  BYP ? 32'h0 : 32'h1);
      step();
    end

    // ---- stall 10 cycles: queue saturates, head held ----
    cpu_stall = 1'b1;
    for (int i = 0; i < 10; i++) step();
    check("stall_occ",   32'(occupancy),  32'h4);
    check("stall_req",   32'(mem_req),    32'h0);
    check("stall_pc",    pc_out,          32'h00400010);
    check("stall_inst",  inst_out,        imem(32'h00400010));
    check("stall_valid", 32'(inst_valid), 32'h1);

    // ---- release: order preserved, refill continues seamlessly ----
    for (int i = 0; i < 6; i++) exp_q.push_back(32'h00400010 + 32'(4 * i));
    cpu_stall = 1'b0;
    settle();
    while (exp_q.size() > 0) begin
      logic [31:0] e;
      e = exp_q.pop_front();
      check("release_pc",    pc_out,          e);
      check("release_valid", 32'(inst_valid), 32'h1);
      step();
    end

    // ---- asynchronous reset in the middle of WAIT ----
    check("pre_rst_wait", 32'(dbg_state), 32'h1);
    rst = 1'b0;
    settle();
    check("arst_req",   32'(mem_req),    32'h0);
    check("arst_valid", 32'(inst_valid), 32'h0);
    check("arst_inst",  inst_out,        32'hffffffff);
    check("arst_addr",  mem_addr,        32'h00400000);
    check("arst_occ",   32'(occupancy),  32'h0);

    // ---- redirect while a request waits -> DROP ----
    auto_mem  = 1'b0;
    cpu_stall = 1'b1;
    step();
    rst = 1'b1;
    step();
    for (int i = 0; i < 3; i++) begin
      man_ack   = 1'b1;
      man_rdata = imem(32'h00400000 + 32'(4 * i));
      step();
    end
    man_ack = 1'b0;
    settle();
    check("wait_addr", mem_addr,        32'h0040000c);
    check("wait_req",  32'(mem_req),    32'h1);
    check("wait_occ",  32'(occupancy),  32'h3);
    step();
    redirect    = 1'b1;
    redirect_pc = 32'h00400102;
    step();
    redirect = 1'b0;
    settle();
    check("drop_state", 32'(dbg_state),  32'h2);
    check("drop_occ",   32'(occupancy),  32'h0);
    check("drop_valid", 32'(inst_valid), 32'h0);
    check("drop_inst",  inst_out,        32'hffffffff);
    check("drop_pc",    pc_out,          32'h00400100);
    check("drop_req",   32'(mem_req),    32'h1);
    check("drop_addr",  mem_addr,        32'h0040000c);
    man_ack   = 1'b1;
    man_rdata = 32'hdeadbeef;
    settle();
    check("drop_ack_valid", 32'(inst_valid), 32'h0);
    step();
    man_ack = 1'b0;
    settle();
    check("post_drop_req", 32'(mem_req),   32'h0);
    check("post_drop_occ", 32'(occupancy), 32'h0);
    step();
    check("refetch_req",  32'(mem_req), 32'h1);
    check("refetch_addr", mem_addr,     32'h00400100);
    cpu_stall = 1'b0;
    man_ack   = 1'b1;
    man_rdata = imem(32'h00400100);
    settle();
    check("ack_cycle_valid", 32'(inst_valid), 32'(BYP));
    if (BYP) begin
      check("bypass_inst", inst_out, 32'h13400100);
      check("bypass_pc",   pc_out,   32'h00400100);
    end
    step();
    man_ack = 1'b0;
    settle();
    check("after_ack_valid", 32'(inst_valid), 32'(!BYP));
    if (!BYP) begin
      check("redir_head_pc",   pc_out,   32'h00400100);
      check("redir_head_inst", inst_out, 32'h13400100);
    end
    check("next_addr", mem_addr,     32'h00400104);
    check("next_req",  32'(mem_req), 32'h1);

    // ---- redirect coincident with ack (and pop when an entry is queued) ----
    man_ack     = 1'b1;
    man_rdata   = imem(32'h00400104);
    redirect    = 1'b1;
    redirect_pc = 32'h00400200;
    settle();
    check("coinc_valid", 32'(inst_valid), 32'(!BYP));
    step();
    man_ack  = 1'b0;
    redirect = 1'b0;
    settle();
    check("coinc_occ",   32'(occupancy),  32'h0);
    check("coinc_vld",   32'(inst_valid), 32'h0);
    check("coinc_inst",  inst_out,        32'hffffffff);
    check("coinc_pc",    pc_out,          32'h00400200);
    check("coinc_req",   32'(mem_req),    32'h0);
    step();
    check("coinc_refetch_req",  32'(mem_req), 32'h1);
    check("coinc_refetch_addr", mem_addr,     32'h00400200);
    check("coinc_pc_hold",      pc_out,       32'h00400200);
    man_ack   = 1'b1;
    man_rdata = imem(32'h00400200);
    step();
    man_ack = 1'b0;
    settle();
    check("coinc_first_valid", 32'(inst_valid), 32'(!BYP));
    check("coinc_first_occ",   32'(occupancy),  BYP ? 32'h0 : 32'h1);
    if (!BYP) begin
      check("coinc_first_pc", pc_out, 32'h00400200);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
